// File: rtl/imm_instr_encoder.sv
// rtl/imm_instr_encoder.sv - RV32I field-to-word encoder with a 2-entry address-tagged output queue.
// Optional build macro IMM_RANGE_CHECK_EN drops beats whose immediate does not fit the format.
module imm_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           ImmSrc,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [2:0]           funct3,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [6:0]           funct7,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_word,
  output logic [31:0]          out_addr,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [31:0]    enc_word;
  logic           fmt_ok;
  logic           word_ok;
  logic           accept;
  logic           push;
  logic           pop;
  logic           drop;
  logic [1:0]     count;
  logic           head;
  logic           tail;
  logic [31:0]    addr_cnt;
  logic [31:0]    mem_word [2];
  logic [31:0]    mem_addr [2];

  // Scatter the immediate back into its RISC-V bit positions; unused fields stay zero.
  always_comb begin
    enc_word = '0;
    fmt_ok   = 1'b1;
    case (ImmSrc)
      3'b000:  enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      3'b001:  enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'b101:  enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'b010:  enc_word = {imm[31:12], rd, opcode};
      3'b110:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      3'b011:  enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      default: fmt_ok   = 1'b0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic imm_ok;

  // Representable means the bits above the format's sign bit are pure sign extension.
  always_comb begin
    imm_ok = 1'b1;
    case (ImmSrc)
      3'b000, 3'b001: imm_ok = (&imm[31:11]) || !(|imm[31:11]);
      3'b101:         imm_ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
      3'b110:         imm_ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
      3'b010:         imm_ok = (imm[11:0] == 12'h000);
      default:        imm_ok = 1'b1;
    endcase
  end

  assign word_ok = fmt_ok && imm_ok;
`else
  assign word_ok = fmt_ok;
`endif

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready && !clr;
  assign push      = accept && word_ok;
  assign drop      = accept && !word_ok;
  assign pop       = out_valid && out_ready && !clr;

  // With the queue empty the address port previews the tag the next word will get.
  assign out_word = out_valid ? mem_word[head] : 32'h0000_0000;
  assign out_addr = out_valid ? mem_addr[head] : addr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head      <= 1'b0;
      tail      <= 1'b0;
      addr_cnt  <= BASE_ADDR;
      err_flag  <= 1'b0;
      err_count <= '0;
    end else if (clr) begin
      count     <= 2'd0;
      head      <= 1'b0;
      tail      <= 1'b0;
      addr_cnt  <= BASE_ADDR;
      err_flag  <= 1'b0;
      err_count <= '0;
    end else begin
      if (push) begin
        tail     <= ~tail;
        addr_cnt <= addr_cnt + 32'd4;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop) begin
        err_flag <= 1'b1;
        if (err_count != '1) begin
          err_count <= err_count + ERR_CNT_W'(1);
        end
      end
    end
  end

  // Payload storage needs no reset: it is only observed while the matching entry is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_word[tail] <= enc_word;
      mem_addr[tail] <= addr_cnt;
    end
  end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// tb/tb_imm_instr_encoder.sv - directed vector bench for imm_instr_encoder.
module tb_imm_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ImmSrc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        err_flag;
  logic [7:0]  err_count;

  imm_instr_encoder #(.BASE_ADDR(BASE), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(ImmSrc), .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr),
    .err_flag(err_flag), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  src;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  vec_t        vecs [6];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input vec_t v);
    ImmSrc = v.src; opcode = v.op; rd = v.rd; funct3 = v.f3;
    rs1 = v.rs1; rs2 = v.rs2; funct7 = v.f7; imm = v.imm;
  endtask

  task automatic set_addi(input logic [31:0] value);
    ImmSrc = 3'b000; opcode = 7'h13; rd = 5'd1; funct3 = 3'd0;
    rs1 = 5'd0; rs2 = 5'd0; funct7 = 7'd0; imm = value;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_addi(32'd0);

    // Vectors carry deliberate garbage in fields the format must ignore.
    vecs[0] = '{"addi", 3'b000, 7'h13, 5'd1, 3'd0, 5'd0, 5'd7, 7'h7F, 32'd5,         32'h0050_0093};
    vecs[1] = '{"sw",   3'b001, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h7F, 32'd8,         32'h0020_A423};
    vecs[2] = '{"beq",  3'b101, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3};
    vecs[3] = '{"lui",  3'b010, 7'h37, 5'd5, 3'd7, 5'd31, 5'd31, 7'h7F, 32'h1234_5000, 32'h1234_52B7};
    vecs[4] = '{"jal",  3'b110, 7'h6F, 5'd1, 3'd7, 5'd31, 5'd31, 7'h7F, 32'h0000_0800, 32'h0010_00EF};
    vecs[5] = '{"add",  3'b011, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'hFFFF_FFFF, 32'h0020_81B3};

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_word",  out_word,       32'd0);
    chk("rst_out_addr",  out_addr,       BASE);
    chk("rst_err_flag",  32'(err_flag),  32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back stream with the consumer always ready.
    exp_addr  = BASE;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_fields(vecs[i]);
      in_valid = 1'b1;
      tick();
      chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      chk({vecs[i].name, "_word"},  out_word,       vecs[i].word);
      chk({vecs[i].name, "_addr"},  out_addr,       exp_addr);
      chk({vecs[i].name, "_ready"}, 32'(in_ready),  32'd1);
      exp_addr = exp_addr + 32'd4;
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(out_valid), 32'd0);
    chk("stream_next_addr", out_addr, exp_addr);

    // Backpressure: two beats fill the queue, the third waits.
    out_ready = 1'b0;
    set_addi(32'd1); in_valid = 1'b1;
    tick();
    chk("bp_first_word", out_word, 32'h0010_0093);
    chk("bp_ready_after1", 32'(in_ready), 32'd1);
    set_addi(32'd2);
    tick();
    chk("bp_ready_after2", 32'(in_ready), 32'd0);
    set_addi(32'd3);
    tick();
    tick();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_hold_word", out_word, 32'h0010_0093);
    chk("bp_hold_addr", out_addr, exp_addr);
    out_ready = 1'b1;
    tick();
    chk("bp_drain2_word", out_word, 32'h0020_0093);
    chk("bp_drain2_addr", out_addr, exp_addr + 32'd4);
    chk("bp_ready_reopen", 32'(in_ready), 32'd1);
    tick();
    chk("bp_third_word", out_word, 32'h0030_0093);
    chk("bp_third_addr", out_addr, exp_addr + 32'd8);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    exp_addr = exp_addr + 32'd12;

    // Illegal formats are swallowed and counted without using an address.
    ImmSrc = 3'b100; in_valid = 1'b1;
    chk("ill_ready", 32'(in_ready), 32'd1);
    tick();
    ImmSrc = 3'b111;
    tick();
    in_valid = 1'b0;
    chk("ill_nothing_queued", 32'(out_valid), 32'd0);
    chk("ill_err_count", 32'(err_count), 32'd2);
    chk("ill_err_flag", 32'(err_flag), 32'd1);
    set_addi(32'd5); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ill_next_addr", out_addr, exp_addr);
    chk("ill_next_word", out_word, 32'h0050_0093);
    tick();

    // Immediate one past the I-format range.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_err_count", 32'(err_count), 32'd0);
    chk("clr_err_flag", 32'(err_flag), 32'd0);
    set_addi(32'd2048); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    chk("rng_dropped", 32'(out_valid), 32'd0);
    chk("rng_err_flag", 32'(err_flag), 32'd1);
    chk("rng_err_count", 32'(err_count), 32'd1);
    set_addi(32'd5); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rng_reuse_addr", out_addr, BASE);
    chk("rng_reuse_word", out_word, 32'h0050_0093);
`else
    chk("trunc_valid", 32'(out_valid), 32'd1);
    chk("trunc_word", out_word, 32'h8000_0093);
    chk("trunc_addr", out_addr, BASE);
    chk("trunc_err_flag", 32'(err_flag), 32'd0);
`endif
    tick();

    // Asynchronous reset while two entries are queued.
    out_ready = 1'b0;
    set_addi(32'd1); in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("arst_pre_full", 32'(in_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_addr", out_addr, BASE);
    chk("arst_out_word", out_word, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    tick();

    // clr wins over a simultaneous push and pop.
    ImmSrc = 3'b100; in_valid = 1'b1;
    tick();
    set_addi(32'd1);
    tick();
    chk("clr_pre_err", 32'(err_count), 32'd1);
    chk("clr_pre_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_empty", 32'(out_valid), 32'd0);
    chk("clr_addr", out_addr, BASE);
    chk("clr_errc", 32'(err_count), 32'd0);
    chk("clr_errf", 32'(err_flag), 32'd0);
    set_addi(32'd7); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("clr_next_addr", out_addr, BASE);
    chk("clr_next_word", out_word, 32'h0070_0093);
    tick();
    chk("clr_next_drained", 32'(out_valid), 32'd0);

    // Error counter saturation.
    ImmSrc = 3'b111; in_valid = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    in_valid = 1'b0;
    chk("sat_err_count", 32'(err_count), 32'h0000_00FF);
    chk("sat_nothing_queued", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
